// File: rtl/scr1_dmem_sram_resp_pkg.sv
// Memory-interface types shared by the DMEM SRAM responder and its SRAM bank.
package scr1_dmem_sram_resp_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_DRESP_FSM_IDLE = 1'b0,
    SCR1_DRESP_FSM_BUSY = 1'b1
  } type_scr1_dresp_fsm_e;

  localparam int unsigned SCR1_DRESP_WAIT_W = 4;
  localparam int unsigned SCR1_DRESP_BE_W   = 4;

  // Byte enables for a store of the given width at the given byte offset
  function automatic logic [SCR1_DRESP_BE_W-1:0] scr1_dresp_be(
    input type_scr1_mem_width_e width,
    input logic [1:0]           offs
  );
    logic [SCR1_DRESP_BE_W-1:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << offs;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << offs;
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_dmem_sram_resp_bank.sv
// Word-wide single-port SRAM with byte enables; read data holds until the next read.
module scr1_dmem_sram_resp_bank
  import scr1_dmem_sram_resp_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic                                clk,
  input  logic                                i_en,
  input  logic                                i_we,
  input  logic [SCR1_DRESP_BE_W-1:0]          i_be,
  input  logic [$clog2(WORDS)-1:0]            i_addr,
  input  logic [31:0]                         i_wdata,
  output logic [31:0]                         o_rdata
);

`ifdef SCR1_DRESP_SRAM_MACRO
  scr1_sram_1p_be #(.WORDS(WORDS)) u_macro (
    .clk   (clk),
    .ce    (i_en),
    .we    (i_we),
    .be    (i_be),
    .addr  (i_addr),
    .wdata (i_wdata),
    .rdata (o_rdata)
  );
`else
  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Byte-enabled write or synchronous read; a write leaves the read register untouched
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/scr1_dmem_sram_resp.sv
// DMEM responder: one transaction at a time onto a byte-enabled SRAM with programmable wait states.
module scr1_dmem_sram_resp
  import scr1_dmem_sram_resp_pkg::*;
#(
  parameter int unsigned                  SCR1_DRESP_AWIDTH = 32,
  parameter int unsigned                  SCR1_DRESP_DWIDTH = 32,
  parameter int unsigned                  SCR1_DRESP_WORDS  = 1024,
  parameter logic [SCR1_DRESP_AWIDTH-1:0] SCR1_DRESP_BASE   = SCR1_DRESP_AWIDTH'(32'h0001_0000),
  parameter int unsigned                  SCR1_DRESP_WAIT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem2resp_req_i,
  input  type_scr1_mem_cmd_e            dmem2resp_cmd_i,
  input  type_scr1_mem_width_e          dmem2resp_width_i,
  input  logic [SCR1_DRESP_AWIDTH-1:0]  dmem2resp_addr_i,
  input  logic [SCR1_DRESP_DWIDTH-1:0]  dmem2resp_wdata_i,
  output logic                          resp2dmem_req_ack_o,
  output logic [SCR1_DRESP_DWIDTH-1:0]  resp2dmem_rdata_o,
  output type_scr1_mem_resp_e           resp2dmem_resp_o
);

  localparam int unsigned IDX_W   = $clog2(SCR1_DRESP_WORDS);
  localparam int unsigned TAG_LSB = IDX_W + 2;
  localparam logic [SCR1_DRESP_WAIT_W-1:0] WAIT_LD = SCR1_DRESP_WAIT_W'(SCR1_DRESP_WAIT);

  type_scr1_dresp_fsm_e          r_state, w_state_next;
  logic [SCR1_DRESP_WAIT_W-1:0]  r_cnt, w_cnt_next;
  logic                          r_req_ack, w_req_ack_next;
  type_scr1_mem_resp_e           r_resp, w_resp_next;
  type_scr1_mem_cmd_e            r_cmd;
  type_scr1_mem_width_e          r_width;
  logic [1:0]                    r_offs;
  logic                          r_fault;

  logic                          w_accept;
  logic                          w_range_ok;
  logic                          w_misalign;
  logic                          w_enc_bad;
  logic                          w_fault;
  logic                          w_sram_en;
  logic                          w_sram_we;
  logic [SCR1_DRESP_BE_W-1:0]    w_be;
  logic [SCR1_DRESP_DWIDTH-1:0]  w_lanes;
  logic [SCR1_DRESP_DWIDTH-1:0]  w_sram_rdata;
  logic [SCR1_DRESP_DWIDTH-1:0]  w_rdata_al;

  assign w_accept = (r_state == SCR1_DRESP_FSM_IDLE) & dmem2resp_req_i;

  // Base is aligned to the bank size, so range is a compare of the upper address bits
  assign w_range_ok = (dmem2resp_addr_i[SCR1_DRESP_AWIDTH-1:TAG_LSB]
                       == SCR1_DRESP_BASE[SCR1_DRESP_AWIDTH-1:TAG_LSB]);

  // Alignment and encoding checks of the incoming request
  always_comb begin
    w_misalign = 1'b0;
    case (dmem2resp_width_i)
      SCR1_MEM_WIDTH_HWORD: w_misalign = dmem2resp_addr_i[0];
      SCR1_MEM_WIDTH_WORD:  w_misalign = |dmem2resp_addr_i[1:0];
      default:              w_misalign = 1'b0;
    endcase
    w_enc_bad = !(dmem2resp_width_i inside {SCR1_MEM_WIDTH_BYTE, SCR1_MEM_WIDTH_HWORD,
                                            SCR1_MEM_WIDTH_WORD})
              | !(dmem2resp_cmd_i inside {SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR});
  end

  assign w_fault   = ~w_range_ok | w_misalign | w_enc_bad;
  assign w_sram_en = w_accept & ~w_fault & ~rst;
  assign w_sram_we = w_sram_en & (dmem2resp_cmd_i == SCR1_MEM_CMD_WR);
  assign w_be      = scr1_dresp_be(dmem2resp_width_i, dmem2resp_addr_i[1:0]);

  // Replicate store data across lanes; byte enables pick the addressed ones
  always_comb begin
    w_lanes = dmem2resp_wdata_i;
    case (dmem2resp_width_i)
      SCR1_MEM_WIDTH_BYTE:  w_lanes = {4{dmem2resp_wdata_i[7:0]}};
      SCR1_MEM_WIDTH_HWORD: w_lanes = {2{dmem2resp_wdata_i[15:0]}};
      default:              w_lanes = dmem2resp_wdata_i;
    endcase
  end

  scr1_dmem_sram_resp_bank #(.WORDS(SCR1_DRESP_WORDS)) u_bank (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_be    (w_be),
    .i_addr  (dmem2resp_addr_i[IDX_W+1:2]),
    .i_wdata (w_lanes),
    .o_rdata (w_sram_rdata)
  );

  // Next-state, wait counter and response; the response is registered one edge ahead
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_resp_next  = SCR1_MEM_RESP_NOTRDY;
    case (r_state)
      SCR1_DRESP_FSM_IDLE: begin
        if (w_accept) begin
          w_state_next = SCR1_DRESP_FSM_BUSY;
          w_cnt_next   = WAIT_LD;
        end
      end
      SCR1_DRESP_FSM_BUSY: begin
        if (r_cnt != '0) w_cnt_next   = r_cnt - SCR1_DRESP_WAIT_W'(1);
        else             w_state_next = SCR1_DRESP_FSM_IDLE;
      end
      default: begin
        w_state_next = SCR1_DRESP_FSM_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if ((w_state_next == SCR1_DRESP_FSM_BUSY) && (w_cnt_next == '0)) begin
      w_resp_next = (w_accept ? w_fault : r_fault) ? SCR1_MEM_RESP_RDY_ER
                                                   : SCR1_MEM_RESP_RDY_OK;
    end
    w_req_ack_next = (w_state_next == SCR1_DRESP_FSM_IDLE);
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCR1_DRESP_FSM_IDLE;
      r_cnt     <= '0;
      r_req_ack <= 1'b1;
      r_resp    <= SCR1_MEM_RESP_NOTRDY;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_req_ack <= w_req_ack_next;
      r_resp    <= w_resp_next;
    end
  end

  // Capture request attributes needed later for read alignment and fault reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd   <= SCR1_MEM_CMD_RD;
      r_width <= SCR1_MEM_WIDTH_BYTE;
      r_offs  <= 2'b00;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_cmd   <= dmem2resp_cmd_i;
      r_width <= dmem2resp_width_i;
      r_offs  <= dmem2resp_addr_i[1:0];
      r_fault <= w_fault;
    end
  end

  // Right-align the addressed lane(s) of the held SRAM word
  always_comb begin
    w_rdata_al = '0;
    case (r_width)
      SCR1_MEM_WIDTH_BYTE: begin
        case (r_offs)
          2'd0:    w_rdata_al = {24'b0, w_sram_rdata[7:0]};
          2'd1:    w_rdata_al = {24'b0, w_sram_rdata[15:8]};
          2'd2:    w_rdata_al = {24'b0, w_sram_rdata[23:16]};
          default: w_rdata_al = {24'b0, w_sram_rdata[31:24]};
        endcase
      end
      SCR1_MEM_WIDTH_HWORD: w_rdata_al = r_offs[1] ? {16'b0, w_sram_rdata[31:16]}
                                                   : {16'b0, w_sram_rdata[15:0]};
      SCR1_MEM_WIDTH_WORD:  w_rdata_al = w_sram_rdata;
      default:              w_rdata_al = '0;
    endcase
  end

  assign resp2dmem_req_ack_o = r_req_ack;
  assign resp2dmem_resp_o    = r_resp;
  assign resp2dmem_rdata_o   = ((r_resp == SCR1_MEM_RESP_RDY_OK) && (r_cmd == SCR1_MEM_CMD_RD))
                               ? w_rdata_al : '0;

endmodule

// File: tb/tb_scr1_dmem_sram_resp.sv
// Self-checking bench: a WAIT=0 and a WAIT=3 instance against a byte-level memory model.
module tb_scr1_dmem_sram_resp;
  import scr1_dmem_sram_resp_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] LIMIT = 32'h0001_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic req = 1'b0;
  type_scr1_mem_cmd_e   cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic req0, req3, ack0, ack3;
  logic [31:0] rdata0, rdata3;
  type_scr1_mem_resp_e resp0, resp3;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_mem [2][1024];

  assign req0 = req & ~sel;
  assign req3 = req & sel;

  always #5 clk = ~clk;

  scr1_dmem_sram_resp #(.SCR1_DRESP_WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .dmem2resp_req_i(req0), .dmem2resp_cmd_i(cmd), .dmem2resp_width_i(width),
    .dmem2resp_addr_i(addr), .dmem2resp_wdata_i(wdata),
    .resp2dmem_req_ack_o(ack0), .resp2dmem_rdata_o(rdata0), .resp2dmem_resp_o(resp0)
  );

  scr1_dmem_sram_resp #(.SCR1_DRESP_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .dmem2resp_req_i(req3), .dmem2resp_cmd_i(cmd), .dmem2resp_width_i(width),
    .dmem2resp_addr_i(addr), .dmem2resp_wdata_i(wdata),
    .resp2dmem_req_ack_o(ack3), .resp2dmem_rdata_o(rdata3), .resp2dmem_resp_o(resp3)
  );

  function automatic logic cur_ack();
    return sel ? ack3 : ack0;
  endfunction
  function automatic type_scr1_mem_resp_e cur_resp();
    return sel ? resp3 : resp0;
  endfunction
  function automatic logic [31:0] cur_rdata();
    return sel ? rdata3 : rdata0;
  endfunction

  // Reference model: fault rules and byte-addressed memory
  function automatic void m_apply(input logic s, input type_scr1_mem_cmd_e c,
                                  input type_scr1_mem_width_e w, input logic [31:0] a,
                                  input logic [31:0] d, output type_scr1_mem_resp_e er,
                                  output logic [31:0] ed);
    int size, idx, off;
    bit bad;
    bad = (a < BASE) || (a >= LIMIT) || (w == SCR1_MEM_WIDTH_ERROR) ||
          (w == SCR1_MEM_WIDTH_HWORD && a % 2 != 0) || (w == SCR1_MEM_WIDTH_WORD && a % 4 != 0);
    ed = '0;
    if (bad) begin
      er = SCR1_MEM_RESP_RDY_ER;
      return;
    end
    er   = SCR1_MEM_RESP_RDY_OK;
    size = (w == SCR1_MEM_WIDTH_BYTE) ? 1 : (w == SCR1_MEM_WIDTH_HWORD) ? 2 : 4;
    idx  = int'((a - BASE) / 4);
    off  = int'(a % 4);
    for (int i = 0; i < size; i++) begin
      if (c == SCR1_MEM_CMD_WR) m_mem[s][idx][8*(off+i) +: 8] = d[8*i +: 8];
      else                      ed[8*i +: 8] = m_mem[s][idx][8*(off+i) +: 8];
    end
  endfunction

  // Drive one request, wait for acceptance and the response (bounded)
  task automatic do_txn(input logic s, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] d,
                        output type_scr1_mem_resp_e r, output logic [31:0] rd, output int lat,
                        output logic busy_ack, output logic ack_after, output logic timeout);
    int n;
    @(negedge clk);
    sel = s; cmd = c; width = w; addr = a; wdata = d; req = 1'b1;
    timeout = 1'b0; busy_ack = 1'b0; ack_after = 1'b0; lat = 0;
    r = SCR1_MEM_RESP_NOTRDY; rd = '0; n = 0;
    while (!cur_ack() && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ack()) begin
      timeout = 1'b1;
      req = 1'b0;
      return;
    end
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (cur_resp() == SCR1_MEM_RESP_NOTRDY && lat < 40) begin
      busy_ack |= cur_ack();
      @(negedge clk);
      lat++;
    end
    busy_ack |= cur_ack();
    if (cur_resp() == SCR1_MEM_RESP_NOTRDY) timeout = 1'b1;
    r  = cur_resp();
    rd = cur_rdata();
    @(negedge clk);
    ack_after = cur_ack();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL reset_ack0 got=%b exp=1", ack0); end
    checks++; if (resp0 !== SCR1_MEM_RESP_NOTRDY) begin failures++; $display("FAIL reset_resp0 got=%0d exp=0", resp0); end
    checks++; if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (ack3 !== 1'b1) begin failures++; $display("FAIL reset_ack3 got=%b exp=1", ack3); end
    checks++; if (resp3 !== SCR1_MEM_RESP_NOTRDY) begin failures++; $display("FAIL reset_resp3 got=%0d exp=0", resp3); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
  endtask

  task automatic test_basic();
    type_scr1_mem_resp_e r, er; logic [31:0] rd, ed; int lat; logic ba, aa, to;
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'hDEADBEEF, r, rd, lat, ba, aa, to);
    m_apply(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'hDEADBEEF, er, ed);
    checks++; if (to !== 1'b0 || r !== SCR1_MEM_RESP_RDY_OK) begin failures++; $display("FAIL basic_sw_resp got=%0d to=%b exp=1", r, to); end
    checks++; if (lat != 1) begin failures++; $display("FAIL basic_sw_latency got=%0d exp=1", lat); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (to !== 1'b0 || r !== SCR1_MEM_RESP_RDY_OK) begin failures++; $display("FAIL basic_lw_resp got=%0d to=%b exp=1", r, to); end
    checks++; if (lat != 1) begin failures++; $display("FAIL basic_lw_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_lw_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_lanes();
    type_scr1_mem_resp_e r, er; logic [31:0] rd, ed; int lat; logic ba, aa, to;
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h11223344, r, rd, lat, ba, aa, to);
    m_apply(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h11223344, er, ed);
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h10005, 32'h000000A5, r, rd, lat, ba, aa, to);
    m_apply(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h10005, 32'h000000A5, er, ed);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK) begin failures++; $display("FAIL lanes_sb_resp got=%0d exp=1", r); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'h1122A544) begin failures++; $display("FAIL lanes_lw got=%h resp=%0d exp=1122a544", rd, r); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h10005, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'h000000A5) begin failures++; $display("FAIL lanes_lbu got=%h resp=%0d exp=000000a5", rd, r); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h10006, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'h00001122) begin failures++; $display("FAIL lanes_lh got=%h resp=%0d exp=00001122", rd, r); end
  endtask

  task automatic test_faults();
    type_scr1_mem_resp_e r; logic [31:0] rd; int lat; logic ba, aa, to;
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10002, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_ER || rd !== 32'h0) begin failures++; $display("FAIL fault_lw_misalign resp=%0d data=%h exp=2/0", r, rd); end
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h11000, 32'h12345678, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_ER || rd !== 32'h0) begin failures++; $display("FAIL fault_sw_range resp=%0d data=%h exp=2/0", r, rd); end
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h10005, 32'h0000FFFF, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_ER) begin failures++; $display("FAIL fault_sh_misalign resp=%0d exp=2", r); end
    do_txn(1'b0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h10004, 32'hFFFFFFFF, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_ER) begin failures++; $display("FAIL fault_bad_width resp=%0d exp=2", r); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0000FFFF, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_ER || rd !== 32'h0) begin failures++; $display("FAIL fault_below_base resp=%0d data=%h exp=2/0", r, rd); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'h1122A544) begin failures++; $display("FAIL fault_word_unchanged got=%h resp=%0d exp=1122a544", rd, r); end
  endtask

  task automatic test_wait_states();
    type_scr1_mem_resp_e r, er; logic [31:0] rd, ed; int lat; logic ba, aa, to;
    do_txn(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'hCAFEF00D, r, rd, lat, ba, aa, to);
    m_apply(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'hCAFEF00D, er, ed);
    checks++; if (lat != 4 || r !== SCR1_MEM_RESP_RDY_OK) begin failures++; $display("FAIL wait_sw lat=%0d resp=%0d exp=4/1", lat, r); end
    do_txn(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (lat != 4) begin failures++; $display("FAIL wait_lw_latency got=%0d exp=4", lat); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL wait_ack_while_busy got=%b exp=0", ba); end
    checks++; if (aa !== 1'b1) begin failures++; $display("FAIL wait_ack_after got=%b exp=1", aa); end
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL wait_lw_data got=%h resp=%0d exp=cafef00d", rd, r); end
  endtask

  task automatic test_reset_mid();
    type_scr1_mem_resp_e r, er; logic [31:0] rd, ed; int lat, n, bad_resp, bad_ack; logic ba, aa, to;
    @(negedge clk);
    sel = 1'b1; cmd = SCR1_MEM_CMD_WR; width = SCR1_MEM_WIDTH_WORD; addr = 32'h10008; wdata = 32'h55; req = 1'b1;
    n = 0;
    while (!ack3 && n < 20) begin @(negedge clk); n++; end
    checks++; if (ack3 !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b exp=1", ack3); end
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_apply(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10008, 32'h55, er, ed);
    bad_resp = 0; bad_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp3 !== SCR1_MEM_RESP_NOTRDY) bad_resp++;
      if (ack3 !== 1'b1) bad_ack++;
    end
    checks++; if (bad_resp != 0) begin failures++; $display("FAIL rstmid_no_resp bad_cycles=%0d exp=0", bad_resp); end
    checks++; if (bad_ack != 0) begin failures++; $display("FAIL rstmid_ack_idle bad_cycles=%0d exp=0", bad_ack); end
    do_txn(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10008, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (r !== SCR1_MEM_RESP_RDY_OK || rd !== 32'h00000055) begin failures++; $display("FAIL rstmid_write_kept got=%h resp=%0d exp=00000055", rd, r); end
    do_txn(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10004, 32'h0, r, rd, lat, ba, aa, to);
    checks++; if (rd !== 32'h1122A544) begin failures++; $display("FAIL rstmid_sram_kept got=%h exp=1122a544", rd); end
  endtask

  task automatic test_random();
    type_scr1_mem_resp_e r, er; logic [31:0] rd, ed, a, d; int lat, exp_lat; logic ba, aa, to, s;
    type_scr1_mem_cmd_e c; type_scr1_mem_width_e w;
    for (int si = 0; si < 2; si++) begin
      for (int k = 0; k < 16; k++) begin
        d = $urandom;
        do_txn(1'(si), SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'(4*k), d, r, rd, lat, ba, aa, to);
        m_apply(1'(si), SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'(4*k), d, er, ed);
      end
    end
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      c = type_scr1_mem_cmd_e'(1'($urandom_range(0, 1)));
      w = type_scr1_mem_width_e'(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 9))
        0:       a = LIMIT + 32'($urandom_range(0, 63));
        1:       a = BASE - 32'($urandom_range(1, 64));
        default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      d = $urandom;
      do_txn(s, c, w, a, d, r, rd, lat, ba, aa, to);
      m_apply(s, c, w, a, d, er, ed);
      exp_lat = s ? 4 : 1;
      checks++; if (to !== 1'b0 || r !== er) begin failures++; $display("FAIL rand_resp i=%0d addr=%h w=%0d c=%0d got=%0d exp=%0d", i, a, w, c, r, er); end
      checks++; if (rd !== ed) begin failures++; $display("FAIL rand_rdata i=%0d addr=%h w=%0d c=%0d got=%h exp=%h", i, a, w, c, rd, ed); end
      checks++; if (lat != exp_lat) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back();
    type_scr1_mem_resp_e er; logic [31:0] ed; logic [31:0] expq[$];
    logic accepting; int n_acc, last_acc, k;
    @(negedge clk);
    sel = 1'b0; cmd = SCR1_MEM_CMD_RD; width = SCR1_MEM_WIDTH_WORD; addr = BASE; req = 1'b1;
    accepting = 1'b0; n_acc = 0; last_acc = 0; k = 0;
    for (int c = 0; c < 20; c++) begin
      if (accepting) begin
        ed = expq.pop_front();
        checks++; if (resp0 !== SCR1_MEM_RESP_RDY_OK || rdata0 !== ed) begin failures++; $display("FAIL b2b_resp cyc=%0d resp=%0d data=%h exp=1/%h", c, resp0, rdata0, ed); end
        k++;
        addr = BASE + 32'(4 * (k % 16));
      end else begin
        checks++; if (resp0 !== SCR1_MEM_RESP_NOTRDY) begin failures++; $display("FAIL b2b_idle_resp cyc=%0d got=%0d exp=0", c, resp0); end
      end
      accepting = ack0;
      if (accepting) begin
        m_apply(1'b0, cmd, width, addr, 32'h0, er, ed);
        expq.push_back(ed);
        if (n_acc > 0) begin
          checks++; if (c - last_acc != 2) begin failures++; $display("FAIL b2b_gap cyc=%0d got=%0d exp=2", c, c - last_acc); end
        end
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    if (accepting) begin
      ed = expq.pop_front();
      checks++; if (resp0 !== SCR1_MEM_RESP_RDY_OK || rdata0 !== ed) begin failures++; $display("FAIL b2b_last resp=%0d data=%h exp=1/%h", resp0, rdata0, ed); end
    end
    checks++; if (n_acc != 10) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=10", n_acc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_faults();
    test_wait_states();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
